// File: rtl/sprite_pkg.sv
// Shared sprite types and constants for the sprite asset load path.
// Used by the loader, its byte packer and the sprite RAM wrappers.
package sprite_pkg;

    localparam int SPRITE_PIXELS = 45 * 45;

    typedef logic [18:0] addr_t;
    typedef logic [23:0] rgb_t;

    localparam rgb_t TRANSPARENT_RGB = 24'hffffff;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_FINISH = 2'd2
    } loader_state_e;

endpackage

// File: rtl/sprite_ram_loader_if.sv
// Byte-stream input and sprite RAM write port of the loader.
// master drives the stream and start; slave is the loader itself.
interface sprite_ram_loader_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 24
);
    logic              start;
    logic [ADDR_W-1:0] base_address;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] data_In;
    logic              busy;
    logic              done;

    modport master (
        output start, base_address, byte_in, byte_valid,
        input  byte_ready, we, write_address, data_In, busy, done
    );

    modport slave (
        input  start, base_address, byte_in, byte_valid,
        output byte_ready, we, write_address, data_In, busy, done
    );
endinterface

// File: rtl/rgb_packer.sv
// Collects three consecutive stream bytes into one R,G,B pixel.
// pixel_valid is combinational on the byte that completes a pixel.
module rgb_packer
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       byte_fire,
    input  logic [7:0] byte_in,
    output rgb_t       pixel,
    output logic       pixel_valid
);
    logic [1:0] phase_q, phase_d;
    logic [7:0] r_q, r_d;
    logic [7:0] g_q, g_d;

    // Phase advance and colour capture on each accepted byte
    always_comb begin
        phase_d     = phase_q;
        r_d         = r_q;
        g_d         = g_q;
        pixel_valid = 1'b0;
        pixel       = {r_q, g_q, byte_in};
        if (clr) begin
            phase_d = 2'd0;
        end else if (byte_fire) begin
            case (phase_q)
                2'd0: begin
                    r_d     = byte_in;
                    phase_d = 2'd1;
                end
                2'd1: begin
                    g_d     = byte_in;
                    phase_d = 2'd2;
                end
                default: begin
                    phase_d     = 2'd0;
                    pixel_valid = 1'b1;
                end
            endcase
        end
    end

    // Phase and partial-pixel registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 2'd0;
            r_q     <= 8'd0;
            g_q     <= 8'd0;
        end else begin
            phase_q <= phase_d;
            r_q     <= r_d;
            g_q     <= g_d;
        end
    end
endmodule

// File: rtl/sprite_ram_loader.sv
// Streams a byte-serial sprite image into a sprite RAM write port.
// One RAM write per 3 bytes, consecutive addresses from a base.
module sprite_ram_loader
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = 45,
    parameter int SPRITE_H = 45,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 24
) (
    input  logic Clk,
    input  logic Reset_n,
    sprite_ram_loader_if.slave bus
);
    localparam int PIXELS = SPRITE_W * SPRITE_H;
    localparam int CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIXELS - 1);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic byte_ready;
    logic byte_fire;
    logic clr;
    rgb_t pixel;
    logic pixel_valid;

    assign byte_ready = (state_q == S_LOAD);
    assign byte_fire  = bus.byte_valid && byte_ready;

    rgb_packer u_packer (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .clr         (clr),
        .byte_fire   (byte_fire),
        .byte_in     (bus.byte_in),
        .pixel       (pixel),
        .pixel_valid (pixel_valid)
    );

    // Load sequencing, pixel counting and RAM write generation
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        clr     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    base_d  = bus.base_address;
                    cnt_d   = '0;
                    clr     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (pixel_valid) begin
                    we_d   = 1'b1;
                    addr_d = base_q + ADDR_W'(cnt_q);
                    data_d = DATA_W'(pixel);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_FINISH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and write-port registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign bus.byte_ready    = byte_ready;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_FINISH);
    assign bus.we            = we_q;
    assign bus.write_address = addr_q;
    assign bus.data_In       = data_q;
endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench for sprite_ram_loader: 2x2 and default 45x45.
// Expected writes come from a byte queue: pixel i = bytes 3i..3i+2.
module tb_sprite_ram_loader;
    import sprite_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_ram_loader_if #(.ADDR_W(19), .DATA_W(24)) sif ();
    sprite_ram_loader_if #(.ADDR_W(19), .DATA_W(24)) bif ();

    sprite_ram_loader #(
        .SPRITE_W(2), .SPRITE_H(2), .ADDR_W(19), .DATA_W(24)
    ) u_small (
        .Clk(clk), .Reset_n(rst_n), .bus(sif.slave)
    );

    sprite_ram_loader #(
        .SPRITE_W(45), .SPRITE_H(45), .ADDR_W(19), .DATA_W(24)
    ) u_big (
        .Clk(clk), .Reset_n(rst_n), .bus(bif.slave)
    );

    typedef struct {
        bit   big;
        int   base;
        int   mode;
        bit   rnd;
        int   rst_after;
        int   start_at;
        int   exp_last;
    } row_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit big, input logic st, input logic [18:0] ba,
                         input logic [7:0] b, input logic v);
        if (big) begin
            bif.start = st; bif.base_address = ba;
            bif.byte_in = b; bif.byte_valid = v;
        end else begin
            sif.start = st; sif.base_address = ba;
            sif.byte_in = b; sif.byte_valid = v;
        end
    endtask

    task automatic get_out(input bit big, output logic we, output logic rdy,
                           output logic busy, output logic done,
                           output logic [18:0] addr, output logic [23:0] data);
        if (big) begin
            we = bif.we; rdy = bif.byte_ready; busy = bif.busy;
            done = bif.done; addr = bif.write_address; data = bif.data_In;
        end else begin
            we = sif.we; rdy = sif.byte_ready; busy = sif.busy;
            done = sif.done; addr = sif.write_address; data = sif.data_In;
        end
    endtask

    task automatic check_idle(input bit big, input string tag);
        logic we, rdy, busy, done;
        logic [18:0] a;
        logic [23:0] d;
        get_out(big, we, rdy, busy, done, a, d);
        chk({tag, "_we"}, {31'd0, we}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, rdy}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic load(input row_t r);
        logic [7:0] bq[$];
        int npix, acc, cyc, budget, p;
        bit pend, pend_done, in_load, fin;
        logic [18:0] base, pa, last_addr;
        logic [23:0] pd;
        logic we, rdy, busy, done, v;
        logic [18:0] oa;
        logic [23:0] od;
        logic [7:0] b;
        npix = r.big ? 2025 : 4;
        base = 19'(r.base);
        acc = 0; cyc = 0; pend = 0; pend_done = 0;
        in_load = 1; fin = 0; last_addr = '0;
        pa = '0; pd = '0;
        budget = npix * 12 + 50;
        @(negedge clk);
        drive(r.big, 1'b1, base, 8'h00, 1'b0);
        @(negedge clk);
        drive(r.big, 1'b0, 19'($urandom), 8'h00, 1'b0);
        while (!fin && cyc < budget) begin
            get_out(r.big, we, rdy, busy, done, oa, od);
            chk("we", {31'd0, we}, {31'd0, pend});
            if (pend) begin
                chk("addr", {13'd0, oa}, {13'd0, pa});
                chk("data", {8'd0, od}, {8'd0, pd});
                last_addr = oa;
            end
            chk("done", {31'd0, done}, {31'd0, pend_done});
            chk("busy", {31'd0, busy}, 32'd1);
            chk("rdy", {31'd0, rdy}, {31'd0, in_load});
            if (r.rst_after >= 0 && acc == r.rst_after) begin
                rst_n = 1'b0;
                drive(r.big, 1'b0, '0, '0, 1'b0);
                #1;
                check_idle(r.big, "rst_mid");
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_idle(r.big, "after_rst");
                return;
            end
            if (pend_done) begin
                fin = 1;
                drive(r.big, 1'b1, 19'd500, 8'hAA, 1'b1);
            end else begin
                case (r.mode)
                    0: v = 1'b1;
                    1: v = (cyc % 2 == 0);
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                b = r.rnd ? 8'($urandom) : 8'(acc + 1);
                if (cyc == r.start_at)
                    drive(r.big, 1'b1, 19'd500, b, v);
                else
                    drive(r.big, 1'b0, 19'($urandom), b, v);
                pend = 0;
                if (v && in_load) begin
                    bq.push_back(b);
                    acc++;
                    if (acc % 3 == 0) begin
                        p = acc / 3 - 1;
                        pend = 1;
                        pa = base + 19'(p);
                        pd = {bq[3*p], bq[3*p+1], bq[3*p+2]};
                        if (p == npix - 1) begin
                            pend_done = 1;
                            in_load = 0;
                        end
                    end
                end
                cyc++;
            end
            @(negedge clk);
        end
        if (!fin) begin
            errors++;
            $display("FAIL timeout: load did not finish in %0d cycles", budget);
        end
        drive(r.big, 1'b0, '0, '0, 1'b1);
        check_idle(r.big, "end");
        @(negedge clk);
        check_idle(r.big, "end2");
        drive(r.big, 1'b0, '0, '0, 1'b0);
        if (r.exp_last >= 0)
            chk("last_addr", {13'd0, last_addr}, 32'(r.exp_last));
    endtask

    row_t rows[8];

    initial begin
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        rows[0] = '{0, 0,        0, 0, -1, -1, 3};
        rows[1] = '{0, 0,        1, 0, -1, -1, 3};
        rows[2] = '{0, 'h7FFFE,  0, 0, -1, -1, 1};
        rows[3] = '{0, 0,        2, 1, -1,  5, 3};
        rows[4] = '{0, 'h123,    0, 0,  7, -1, -1};
        rows[5] = '{0, 'h10,     0, 0, -1, -1, 'h13};
        rows[6] = '{1, 100,      0, 0, -1, -1, 2124};
        rows[7] = '{1, 'h7FC00,  2, 1, -1, 40, 'h7FC00 + 2024 - 'h80000};

        rst_n = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 19'd7, '0, 1'b1);
        drive(1'b1, 1'b1, 19'd7, '0, 1'b1);
        repeat (2) @(negedge clk);
        check_idle(1'b0, "rst_s");
        check_idle(1'b1, "rst_b");
        chk("rst_addr", {13'd0, sif.write_address}, 32'd0);
        chk("rst_data", {8'd0, sif.data_In}, 32'd0);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle(1'b0, "post_rst_s");
        check_idle(1'b1, "post_rst_b");

        for (int i = 0; i < 8; i++) load(rows[i]);

        for (int i = 0; i < 10; i++) begin
            row_t r;
            r = '{0, int'($urandom_range(0, 19'h7FFFF)), 2, 1, -1,
                  int'($urandom_range(0, 15)), -1};
            load(r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
